// File: rtl/demux1to8_3bits_buf.sv
// Registered 1-to-8 demultiplexer with a 1-entry valid/ack buffer per lane.
// Routes one WIDTH-bit word per cycle to the lane chosen by sel_i.
module demux1to8_3bits_buf #(
   parameter int unsigned WIDTH = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   in_data_i,
   input  logic [2:0]         sel_i,
   input  logic               flush_i,
   output logic [8*WIDTH-1:0] out_data_o,
   output logic [7:0]         out_valid_o,
   input  logic [7:0]         out_ack_i,
   output logic [3:0]         occupancy_o
);

   logic [7:0]         full_q, full_d;
   logic [8*WIDTH-1:0] data_q, data_d;
   logic [3:0]         occ_q, occ_d;
   logic               accept;

   // An ack in the same cycle frees the addressed lane for a new word.
   assign in_ready_o = !flush_i && (!full_q[sel_i] || out_ack_i[sel_i]);
   assign accept     = in_valid_i && in_ready_o;

   always_comb begin
      full_d = full_q & ~out_ack_i;
      data_d = data_q;
      if (accept) begin
         full_d[sel_i]                         = 1'b1;
         data_d[int'(sel_i) * WIDTH +: WIDTH] = in_data_i;
      end
      if (flush_i) begin
         full_d = '0;
      end
      occ_d = '0;
      for (int i = 0; i < 8; i++) begin
         occ_d = occ_d + 4'(full_d[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= '0;
         data_q <= '0;
         occ_q  <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
         occ_q  <= occ_d;
      end
   end

   assign out_valid_o = full_q;
   assign out_data_o  = data_q;
   assign occupancy_o = occ_q;

endmodule
